// File: rtl/reset_event_sequencer.sv
`default_nettype none
// ============================================================================
// reset_event_sequencer: power-up release and run-time re-sequencing of the
// proc1/rs232 domain resets, with watchdog, cause and count recording.
// Revision: 1.0
// ============================================================================
module reset_event_sequencer #(
    parameter int HOLD_CYCLES = 16,
    parameter int RS232_GAP   = 64,
    parameter int PROC_GAP    = 16,
    parameter int WDT_TIMEOUT = 1048575
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       locked_proc1,
    input  logic       locked_rs232,
    input  logic       dbg_reset_req,
    input  logic       sw_reset_req,
    input  logic       wdt_enable,
    input  logic       wdt_kick,
    output logic       reset_rs232,
    output logic       reset_proc1,
    output logic       running,
    output logic [2:0] reset_cause,
    output logic [7:0] reset_count
);

    localparam int              c_cnt_w     = 16;
    localparam logic [c_cnt_w-1:0] c_rs_last   = c_cnt_w'(RS232_GAP - 1);
    localparam logic [c_cnt_w-1:0] c_proc_last = c_cnt_w'(PROC_GAP - 1);
    localparam logic [c_cnt_w-1:0] c_hold_last = c_cnt_w'(HOLD_CYCLES - 1);
    localparam logic [19:0]     c_wdt_max   = 20'(WDT_TIMEOUT);

    localparam logic [2:0] c_cause_por  = 3'b001;
    localparam logic [2:0] c_cause_lock = 3'b010;
    localparam logic [2:0] c_cause_dbg  = 3'b011;
    localparam logic [2:0] c_cause_wdt  = 3'b100;
    localparam logic [2:0] c_cause_sw   = 3'b101;

    typedef enum logic [2:0] {
        S_WAIT_LOCKED = 3'd0,
        S_COUNT_RS232 = 3'd1,
        S_COUNT_PROC  = 3'd2,
        S_RUNNING     = 3'd3,
        S_HOLD_ALL    = 3'd4,
        S_HOLD_PROC   = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [c_cnt_w-1:0]   cnt_q, cnt_d;
    logic [19:0]          wdt_q, wdt_d;
    logic                 rs232_q, rs232_d;
    logic                 proc1_q, proc1_d;
    logic                 running_q, running_d;
    logic [2:0]           cause_q, cause_d;
    logic [7:0]           count_q, count_d;

    logic                 w_lock_ok;
    logic                 w_wdt_expired;
    logic [7:0]           w_count_inc;

    assign w_lock_ok     = locked_proc1 & locked_rs232;
    assign w_count_inc   = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
    // A kick in the expiry cycle wins, so expiry requires no kick.
    assign w_wdt_expired = wdt_enable && !wdt_kick && (wdt_q == c_wdt_max);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + c_cnt_w'(1);
        wdt_d     = '0;
        rs232_d   = rs232_q;
        proc1_d   = proc1_q;
        running_d = running_q;
        cause_d   = cause_q;
        count_d   = count_q;
        case (state_q)
            S_WAIT_LOCKED: begin
                rs232_d = 1'b1;
                proc1_d = 1'b1;
                cnt_d   = '0;
                if (w_lock_ok) state_d = S_COUNT_RS232;
            end
            S_COUNT_RS232, S_COUNT_PROC: begin
                if (!w_lock_ok) begin
                    rs232_d = 1'b1;
                    proc1_d = 1'b1;
                    cnt_d   = '0;
                    cause_d = c_cause_lock;
                    count_d = w_count_inc;
                    state_d = S_WAIT_LOCKED;
                end else if (state_q == S_COUNT_RS232 && cnt_q == c_rs_last) begin
                    rs232_d = 1'b0;
                    cnt_d   = '0;
                    state_d = S_COUNT_PROC;
                end else if (state_q == S_COUNT_PROC && cnt_q == c_proc_last) begin
                    proc1_d   = 1'b0;
                    running_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_RUNNING;
                end
            end
            S_RUNNING: begin
                cnt_d = '0;
                if (wdt_enable)
                    wdt_d = wdt_kick ? 20'd0 : ((wdt_q == c_wdt_max) ? wdt_q : wdt_q + 20'd1);
                if (!w_lock_ok || dbg_reset_req) begin
                    rs232_d = 1'b1;
                    proc1_d = 1'b1;
                    cause_d = !w_lock_ok ? c_cause_lock : c_cause_dbg;
                    state_d = S_HOLD_ALL;
                end else if (w_wdt_expired || sw_reset_req) begin
                    proc1_d = 1'b1;
                    cause_d = w_wdt_expired ? c_cause_wdt : c_cause_sw;
                    state_d = S_HOLD_PROC;
                end
                if (state_d != S_RUNNING) begin
                    wdt_d     = '0;
                    running_d = 1'b0;
                    count_d   = w_count_inc;
                end
            end
            S_HOLD_ALL: begin
                if (cnt_q == c_hold_last) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_LOCKED;
                end
            end
            S_HOLD_PROC: begin
                if (!w_lock_ok) begin
                    rs232_d = 1'b1;
                    cnt_d   = '0;
                    cause_d = c_cause_lock;
                    count_d = w_count_inc;
                    state_d = S_HOLD_ALL;
                end else if (cnt_q == c_hold_last) begin
                    proc1_d   = 1'b0;
                    running_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_RUNNING;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_WAIT_LOCKED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_WAIT_LOCKED;
            cnt_q     <= '0;
            wdt_q     <= '0;
            rs232_q   <= 1'b1;
            proc1_q   <= 1'b1;
            running_q <= 1'b0;
            cause_q   <= c_cause_por;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wdt_q     <= wdt_d;
            rs232_q   <= rs232_d;
            proc1_q   <= proc1_d;
            running_q <= running_d;
            cause_q   <= cause_d;
            count_q   <= count_d;
        end
    end

    assign reset_rs232 = rs232_q;
    assign reset_proc1 = proc1_q;
    assign running     = running_q;
    assign reset_cause = cause_q;
    assign reset_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_reset_event_sequencer.sv
`default_nettype none
// ============================================================================
// tb_reset_event_sequencer: directed scenario walk with randomized timing,
// compared every cycle against a deadline-based behavioural model.
// Revision: 1.0
// ============================================================================
module tb_reset_event_sequencer;

    localparam int HOLD = 16;
    localparam int RSG  = 64;
    localparam int PG   = 16;
    localparam int WDT  = 100;

    localparam int P_WAIT  = 0;
    localparam int P_RS    = 1;
    localparam int P_PR    = 2;
    localparam int P_RUN   = 3;
    localparam int P_HALL  = 4;
    localparam int P_HPROC = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       locked_proc1 = 1'b0, locked_rs232 = 1'b0;
    logic       dbg_reset_req = 1'b0, sw_reset_req = 1'b0;
    logic       wdt_enable = 1'b0, wdt_kick = 1'b0;
    logic       reset_rs232, reset_proc1, running;
    logic [2:0] reset_cause;
    logic [7:0] reset_count;

    always #5 clk = ~clk;

    reset_event_sequencer #(
        .HOLD_CYCLES(HOLD), .RS232_GAP(RSG), .PROC_GAP(PG), .WDT_TIMEOUT(WDT)
    ) dut (
        .clk(clk), .reset(reset),
        .locked_proc1(locked_proc1), .locked_rs232(locked_rs232),
        .dbg_reset_req(dbg_reset_req), .sw_reset_req(sw_reset_req),
        .wdt_enable(wdt_enable), .wdt_kick(wdt_kick),
        .reset_rs232(reset_rs232), .reset_proc1(reset_proc1), .running(running),
        .reset_cause(reset_cause), .reset_count(reset_count)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: phase plus the absolute edge number at which the phase ends.
    int         m_phase = P_WAIT, m_tend = 0, m_wdt = 0, m_count = 0;
    logic       m_rs = 1'b1, m_pr = 1'b1, m_run = 1'b0;
    logic [2:0] m_cause = 3'b001;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v < 255) ? v + 1 : 255;
    endfunction

    function automatic void enter_hold(input logic all, input logic [2:0] c);
        m_phase = all ? P_HALL : P_HPROC;
        m_tend  = cyc + HOLD;
        m_count = sat_inc(m_count);
        m_cause = c;
        m_run   = 1'b0;
        m_wdt   = 0;
        m_pr    = 1'b1;
        if (all) m_rs = 1'b1;
    endfunction

    function automatic void resume_run();
        m_pr = 1'b0; m_run = 1'b1; m_phase = P_RUN; m_wdt = 0;
    endfunction

    function automatic void model_step();
        logic lk;
        lk = locked_proc1 & locked_rs232;
        if (reset) begin
            m_phase = P_WAIT; m_rs = 1'b1; m_pr = 1'b1; m_run = 1'b0;
            m_cause = 3'b001; m_count = 0; m_wdt = 0;
        end else begin
            case (m_phase)
                P_WAIT: if (lk) begin m_phase = P_RS; m_tend = cyc + RSG; end
                P_RS, P_PR: begin
                    if (!lk) begin
                        m_rs = 1'b1; m_pr = 1'b1; m_phase = P_WAIT;
                        m_cause = 3'b010; m_count = sat_inc(m_count);
                    end else if (cyc == m_tend && m_phase == P_RS) begin
                        m_rs = 1'b0; m_phase = P_PR; m_tend = cyc + PG;
                    end else if (cyc == m_tend) begin
                        resume_run();
                    end
                end
                P_RUN: begin
                    if (!lk) enter_hold(1'b1, 3'b010);
                    else if (dbg_reset_req) enter_hold(1'b1, 3'b011);
                    else if (wdt_enable && !wdt_kick && m_wdt == WDT) enter_hold(1'b0, 3'b100);
                    else if (sw_reset_req) enter_hold(1'b0, 3'b101);
                    else m_wdt = (!wdt_enable || wdt_kick) ? 0 : m_wdt + 1;
                end
                P_HALL: if (cyc == m_tend) m_phase = P_WAIT;
                P_HPROC: begin
                    if (!lk) enter_hold(1'b1, 3'b010);
                    else if (cyc == m_tend) resume_run();
                end
                default: m_phase = P_WAIT;
            endcase
        end
    endfunction

    task automatic tick();
        cyc++;
        model_step();
        @(posedge clk);
        #1;
        chk("rs232",   32'(reset_rs232), 32'(m_rs));
        chk("proc1",   32'(reset_proc1), 32'(m_pr));
        chk("running", 32'(running),     32'(m_run));
        chk("cause",   32'(reset_cause), 32'(m_cause));
        chk("count",   32'(reset_count), 32'(m_count));
    endtask

    task automatic pulse(input logic d, input logic s);
        dbg_reset_req = d; sw_reset_req = s;
        tick();
        dbg_reset_req = 1'b0; sw_reset_req = 1'b0;
    endtask

    function automatic logic cond(input int which);
        case (which)
            0: return reset_rs232 == 1'b0;
            1: return reset_proc1 == 1'b0;
            2: return running == 1'b1;
            default: return reset_proc1 == 1'b1;
        endcase
    endfunction

    task automatic wait_for(input string tag, input int which, input int limit, output int n);
        n = 0;
        while (!cond(which) && n < limit) begin
            tick();
            n++;
        end
        chk(tag, 32'(cond(which)), 32'd1);
    endtask

    initial begin
        int n, k, base;

        // Reset state
        tick(); tick();
        chk("por_rs232", 32'(reset_rs232), 32'd1);
        chk("por_proc1", 32'(reset_proc1), 32'd1);
        chk("por_running", 32'(running), 32'd0);
        chk("por_cause", 32'(reset_cause), 32'd1);
        chk("por_count", 32'(reset_count), 32'd0);
        reset = 1'b0;

        // 1: power-up release, locks at cycle 10
        repeat (10) tick();
        locked_proc1 = 1'b1; locked_rs232 = 1'b1;
        wait_for("t1_rs232_fall", 0, 200, n);
        chk("t1_rs232_latency", 32'(n), 32'(RSG + 1));
        wait_for("t1_proc1_fall", 1, 200, n);
        chk("t1_proc1_latency", 32'(n), 32'(PG));
        chk("t1_running", 32'(running), 32'd1);
        chk("t1_cause", 32'(reset_cause), 32'd1);

        // 2: software reset with ignored noise during the hold
        repeat ($urandom_range(0, 20)) tick();
        pulse(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) pulse($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        wait_for("t2_proc1_fall", 1, 100, n);
        chk("t2_hold_len", 32'(n + 5), 32'(HOLD));
        chk("t2_rs232", 32'(reset_rs232), 32'd0);
        chk("t2_cause", 32'(reset_cause), 32'b101);
        chk("t2_count", 32'(reset_count), 32'd1);

        // 3: watchdog expiry, then kicked watchdog survives
        wdt_enable = 1'b1;
        wait_for("t3_wdt_fire", 3, 300, n);
        chk("t3_wdt_latency", 32'(n), 32'(WDT + 1));
        chk("t3_cause", 32'(reset_cause), 32'b100);
        chk("t3_count", 32'(reset_count), 32'd2);
        wait_for("t3_resume", 2, 100, n);
        for (int i = 0; i < 1000; i++) begin
            wdt_kick = (i % 50 == 49);
            tick();
        end
        wdt_kick = 1'b0;
        chk("t3_kicked_running", 32'(running), 32'd1);
        chk("t3_kicked_count", 32'(reset_count), 32'd2);
        wdt_enable = 1'b0;

        // 4: rs232 lock loss
        locked_rs232 = 1'b0;
        tick();
        chk("t4_rs232", 32'(reset_rs232), 32'd1);
        chk("t4_proc1", 32'(reset_proc1), 32'd1);
        k = $urandom_range(3, 8);
        for (int i = 1; i < k; i++) pulse($urandom_range(0, 1) == 1, 1'b0);
        locked_rs232 = 1'b1;
        wait_for("t4_resume", 2, 300, n);
        chk("t4_cause", 32'(reset_cause), 32'b010);
        chk("t4_count", 32'(reset_count), 32'd3);

        // 5: simultaneous dbg + sw + watchdog expiry
        wdt_enable = 1'b1;
        n = 0;
        while (m_wdt != WDT && n < 200) begin tick(); n++; end
        chk("t5_wdt_reached", 32'(m_wdt), 32'(WDT));
        pulse(1'b1, 1'b1);
        wdt_enable = 1'b0;
        chk("t5_cause", 32'(reset_cause), 32'b011);
        chk("t5_count", 32'(reset_count), 32'd4);
        chk("t5_rs232", 32'(reset_rs232), 32'd1);
        wait_for("t5_resume", 2, 300, n);
        // escalation from HOLD_PROC
        pulse(1'b0, 1'b1);
        repeat ($urandom_range(1, 10)) tick();
        locked_proc1 = 1'b0;
        tick();
        chk("t5_esc_cause", 32'(reset_cause), 32'b010);
        chk("t5_esc_count", 32'(reset_count), 32'd6);
        chk("t5_esc_rs232", 32'(reset_rs232), 32'd1);
        locked_proc1 = 1'b1;
        wait_for("t5_esc_resume", 2, 300, n);

        // 6: saturation, then reset mid-COUNT_RS232
        base = m_count;
        for (int i = 0; i < 300; i++) begin
            pulse(1'b0, 1'b1);
            wait_for("t6_resume", 2, 40, n);
        end
        chk("t6_sat_count", 32'(reset_count), 32'd255);
        chk("t6_sat_model", 32'(base + 300 >= 255), 32'd1);
        locked_proc1 = 1'b0;
        tick();
        locked_proc1 = 1'b1;
        repeat (HOLD + 1 + $urandom_range(2, 40)) tick();
        chk("t6_mid_rs232", 32'(reset_rs232), 32'd1);
        chk("t6_mid_count", 32'(reset_count), 32'd255);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_rst_rs232", 32'(reset_rs232), 32'd1);
        chk("t6_rst_proc1", 32'(reset_proc1), 32'd1);
        chk("t6_rst_running", 32'(running), 32'd0);
        chk("t6_rst_cause", 32'(reset_cause), 32'b001);
        chk("t6_rst_count", 32'(reset_count), 32'd0);
        wait_for("t6_final_resume", 2, 300, n);
        chk("t6_final_cause", 32'(reset_cause), 32'b001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reset_event_sequencer.md
Name: reset_event_sequencer

Overview:
- Run-time reset manager for the proc1 and rs232 clock domains.
- Performs the post-lock power-up release sequence.
- Afterwards, monitors PLL lock loss, debug reset requests, software reset requests and a watchdog, and re-sequences the affected domain resets.
- Records the last reset cause and a reset count for proc1 to read.

Parameters:
HOLD_CYCLES, 16, cycles resets are held asserted after a run-time event before release or lock wait
RS232_GAP, 64, cycles from entering COUNT_RS232 to reset_rs232 deassertion
PROC_GAP, 16, cycles from reset_rs232 deassertion to reset_proc1 deassertion
WDT_TIMEOUT, 1048575, watchdog expiry count (20-bit)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
locked_proc1  input  1  proc1 clock generator locked
locked_rs232  input  1  rs232 clock generator locked
dbg_reset_req  input  1  one-cycle pulse from rs232 debug command: full reset
sw_reset_req  input  1  one-cycle pulse from proc1: proc1-only reset
wdt_enable  input  1  level; watchdog active while high
wdt_kick  input  1  one-cycle pulse; clears watchdog counter
reset_rs232  output  1  rs232 domain reset, active high
reset_proc1  output  1  proc1 domain reset, active high
running  output  1  high while state is RUNNING
reset_cause  output  3  last cause: 001 power-on, 010 lock loss, 011 debug, 100 watchdog, 101 software
reset_count  output  8  saturating count of non-power-on resets

Behaviour:
- All outputs are registered. On clk, the synchronous, active-high reset sets:
  - reset_rs232=1, reset_proc1=1, running=0, reset_cause=001, reset_count=0
  - watchdog counter=0, sequence counter=0, state=WAIT_LOCKED
- States: WAIT_LOCKED, COUNT_RS232, COUNT_PROC, RUNNING, HOLD_ALL, HOLD_PROC.
- WAIT_LOCKED:
  - Both resets held at 1.
  - When locked_proc1 & locked_rs232: counter<=0, go to COUNT_RS232.
- COUNT_RS232:
  - Counter increments each cycle.
  - When counter==RS232_GAP-1: reset_rs232<=0, counter<=0, go to COUNT_PROC.
  - reset_rs232 is therefore low exactly RS232_GAP cycles after entry.
- COUNT_PROC:
  - Counter increments each cycle.
  - When counter==PROC_GAP-1: reset_proc1<=0, go to RUNNING.
- RUNNING: running=1. Events are evaluated each cycle, in priority order:
  1. Lock loss (either locked low): cause 010, go to HOLD_ALL.
  2. dbg_reset_req: cause 011, go to HOLD_ALL.
  3. Watchdog expiry: cause 100, go to HOLD_PROC.
  4. sw_reset_req: cause 101, go to HOLD_PROC.
- Entry into either HOLD state:
  - counter<=0
  - reset_count increments, saturating at 255
  - reset_cause updated
  - running<=0
  - HOLD_ALL sets both resets to 1; HOLD_PROC sets reset_proc1 to 1 only.
- HOLD_ALL: after HOLD_CYCLES cycles, go to WAIT_LOCKED.
- HOLD_PROC:
  - After HOLD_CYCLES cycles: reset_proc1<=0, go to RUNNING. reset_rs232 stays 0 throughout.
  - Lock loss during HOLD_PROC escalates to HOLD_ALL, cause 010, counter restarts, count increments again.
- Lock loss in COUNT_RS232 or COUNT_PROC:
  - Both resets to 1, go to WAIT_LOCKED.
  - Cause 010; count increments.
- Requests arriving outside RUNNING are ignored and not queued. The exception is lock loss, handled as stated above.
- Watchdog:
  - 20-bit counter, active only in RUNNING with wdt_enable=1; otherwise held at 0.
  - wdt_kick clears the counter to 0; kick in the same cycle as reaching WDT_TIMEOUT wins, so no expiry.
  - Expiry when counter==WDT_TIMEOUT.
  - Counter clears on leaving RUNNING.
- Simultaneous events in RUNNING resolve by the priority order above; lower-priority pulses in that cycle are dropped.
- Reset assertion mid-sequence restarts from WAIT_LOCKED with cause 001 and count 0.

Test Plan:
1. Reset, then raise both locks at cycle 10 → reset_rs232 falls 64 cycles after COUNT_RS232 entry; reset_proc1 falls 16 cycles later; running=1; cause=001, count=0.
2. In RUNNING, pulse sw_reset_req → reset_proc1=1 for 16 cycles, reset_rs232 stays 0, running returns; cause=101, count=1.
3. WDT_TIMEOUT=100, wdt_enable=1, no kicks → proc1-only reset at watchdog count 100; cause=100. Repeat with a kick every 50 cycles → no reset for 1000 cycles.
4. In RUNNING, drop locked_rs232 for 5 cycles → both resets asserted; HOLD 16 cycles, then WAIT_LOCKED, then the full release sequence; cause=010.
5. Same cycle: dbg_reset_req, sw_reset_req and watchdog expiry → HOLD_ALL, cause=011, count increments by exactly 1. Also, drop locked_proc1 during HOLD_PROC → escalates to HOLD_ALL, cause=010.
6. Force 300 sw resets → reset_count saturates at 255. Then assert reset mid-COUNT_RS232 → both resets 1, count 0, cause 001.
